// File: rtl/chroma_carrier_gen.sv
// NTSC chroma carrier generator: free-running 16-phase carrier, burst window FSM,
// and a 3-stage sine-lookup/amplitude pipeline producing one signed chroma sample per tick.
module chroma_carrier_gen #(
  parameter int BURST_START = 76,
  parameter int BURST_LEN   = 144,
  parameter int BURST_PHASE = 8,
  parameter int OUT_W       = 8
) (
  input  logic             clk_col16x,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             line_sync,
  input  logic [3:0]       chroma_phase,
  input  logic [3:0]       chroma_amp,
  input  logic             chroma_en,
  input  logic [3:0]       burst_amp,
  output logic [3:0]       carrier_phase,
  output logic             burst_active,
  output logic [OUT_W-1:0] chroma_out,
  output logic             out_valid
);
  localparam int STAGES = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [7:0] LP_WAIT_END  = 8'(BURST_START - 1);
  localparam logic [7:0] LP_BURST_END = 8'(BURST_LEN - 1);
  localparam logic [3:0] LP_BPHASE    = 4'(BURST_PHASE);

  logic [3:0]        r_carrier;
  logic [1:0]        r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              w_burst_sel;

  logic [3:0]        r_idx;
  logic [3:0]        r_amp1, r_amp2;
  logic signed [7:0] r_sin, w_sin;
  logic [OUT_W-1:0]  r_out;
  logic [STAGES-1:0] r_vld_pipe;
  logic [STAGES-1:0] r_bsel_pipe;

  logic signed [12:0] w_sin_x, w_amp_x, w_prod_full;
  logic signed [11:0] w_prod, w_shift;

  assign w_burst_sel = (r_state == S_BURST);

  // line_sync from any state restarts the wait, taking priority over terminal counts
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (line_sync) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == LP_WAIT_END) begin
            w_state_nxt = S_BURST;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        S_BURST: begin
          if (r_cnt == LP_BURST_END) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        S_IDLE: ;
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_sin = 8'sd0;
    case (r_idx)
      4'd0:  w_sin = 8'sd0;
      4'd1:  w_sin = 8'sd49;
      4'd2:  w_sin = 8'sd90;
      4'd3:  w_sin = 8'sd117;
      4'd4:  w_sin = 8'sd127;
      4'd5:  w_sin = 8'sd117;
      4'd6:  w_sin = 8'sd90;
      4'd7:  w_sin = 8'sd49;
      4'd8:  w_sin = 8'sd0;
      4'd9:  w_sin = -8'sd49;
      4'd10: w_sin = -8'sd90;
      4'd11: w_sin = -8'sd117;
      4'd12: w_sin = -8'sd127;
      4'd13: w_sin = -8'sd117;
      4'd14: w_sin = -8'sd90;
      4'd15: w_sin = -8'sd49;
      default: w_sin = 8'sd0;
    endcase
  end

  // |s*amp| <= 1905, so the 12-bit product never overflows
  assign w_sin_x     = {{5{r_sin[7]}}, r_sin};
  assign w_amp_x     = {9'd0, r_amp2};
  assign w_prod_full = w_sin_x * w_amp_x;
  assign w_prod      = w_prod_full[11:0];
  assign w_shift     = w_prod >>> 4;

  always_ff @(posedge clk_col16x or negedge reset_n) begin
    if (!reset_n) begin
      r_carrier   <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_amp1      <= '0;
      r_amp2      <= '0;
      r_sin       <= '0;
      r_out       <= '0;
      r_vld_pipe  <= '0;
      r_bsel_pipe <= '0;
    end else if (enable) begin
      r_carrier   <= r_carrier + 4'd1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= r_carrier + (w_burst_sel ? LP_BPHASE : chroma_phase);
      r_amp1      <= w_burst_sel ? burst_amp : (chroma_en ? chroma_amp : 4'd0);
      r_sin       <= w_sin;
      r_amp2      <= r_amp1;
      r_out       <= OUT_W'(w_shift);
      r_vld_pipe  <= {r_vld_pipe[STAGES-2:0], 1'b1};
      r_bsel_pipe <= {r_bsel_pipe[STAGES-2:0], w_burst_sel};
    end
  end

  assign carrier_phase = r_carrier;
  assign burst_active  = r_bsel_pipe[STAGES-1];
  assign chroma_out    = r_out;
  assign out_valid     = r_vld_pipe[STAGES-1];
endmodule

// File: tb/tb_chroma_carrier_gen.sv
// Randomized scoreboard bench for chroma_carrier_gen: an enabled-tick reference model
// pushes expected samples, a negedge monitor pops them as the DUT presents output.
module tb_chroma_carrier_gen;
  localparam int BS = 76;
  localparam int BL = 144;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ls = 1'b0;
  logic [3:0] ph = '0, amp = '0, bamp = '0;
  logic       cen = 1'b0;
  logic [3:0] cp;
  logic       ba, ov;
  logic [7:0] co;

  chroma_carrier_gen dut (
    .clk_col16x(clk), .reset_n(rst_n), .enable(en), .line_sync(ls),
    .chroma_phase(ph), .chroma_amp(amp), .chroma_en(cen), .burst_amp(bamp),
    .carrier_phase(cp), .burst_active(ba), .chroma_out(co), .out_valid(ov)
  );

  always #5 clk = ~clk;

  typedef struct { int val; bit b; } exp_t;
  exp_t q[$];
  exp_t last_exp;
  exp_t mon_x;
  int   checks = 0;
  int   failures = 0;
  int   e = 0;
  int   last_sync = 0;
  bit   have_sync = 1'b0;
  bit   new_edge = 1'b0;
  bit   froze = 1'b0;
  int   SIN[16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int floor16(input int p);
    return (p >= 0) ? p / 16 : -((-p + 15) / 16);
  endfunction

  task automatic model_reset();
    q.delete();
    e = 0; have_sync = 1'b0; last_sync = 0;
    new_edge = 1'b0; froze = 1'b0;
    last_exp.val = 0; last_exp.b = 1'b0;
  endtask

  // One clock; on an enabled edge the model derives carrier from the tick count
  // and the burst window from the distance to the last accepted line_sync.
  task automatic tick();
    int d, idx, a;
    bit b;
    exp_t x;
    @(posedge clk);
    if (rst_n) begin
      if (en) begin
        e++;
        d = e - last_sync;
        b = have_sync && (d >= BS + 1) && (d <= BS + BL);
        idx = ((e - 1) + (b ? 8 : int'(ph))) % 16;
        a = b ? int'(bamp) : (cen ? int'(amp) : 0);
        x.val = floor16(SIN[idx] * a);
        x.b = b;
        q.push_back(x);
        if (ls) begin
          have_sync = 1'b1;
          last_sync = e;
        end
        new_edge = 1'b1;
      end else begin
        froze = 1'b1;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sync();
    ls = 1'b1;
    tick();
    ls = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_chroma", int'(co), 0);
      chk("rst_carrier", int'(cp), 0);
      chk("rst_valid", int'(ov), 0);
      chk("rst_burst", int'(ba), 0);
    end else if (new_edge) begin
      new_edge = 1'b0;
      chk("carrier", int'(cp), e % 16);
      chk("out_valid", int'(ov), int'(e >= 3));
      if (ov) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual=valid_sample required=no_sample (t=%0t)", $time);
        end else begin
          mon_x = q.pop_front();
          chk("chroma", int'($signed(co)), mon_x.val);
          chk("burst_active", int'(ba), int'(mon_x.b));
          last_exp = mon_x;
        end
      end
    end else if (froze) begin
      froze = 1'b0;
      chk("frozen_carrier", int'(cp), e % 16);
      chk("frozen_chroma", int'($signed(co)), last_exp.val);
      chk("frozen_burst", int'(ba), int'(last_exp.b));
      chk("frozen_valid", int'(ov), int'(e >= 3));
    end
  end

  initial begin
    model_reset();
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; cen = 1'b1; amp = 4'd15; ph = 4'd0; bamp = 4'd15;

    // carrier wrap and the known phase-0 sine sequence
    run(4);
    #3;
    chk("tick4_chroma", int'($signed(co)), 45);
    run(30);

    // single line: full burst window
    pulse_sync();
    run(300);

    // mid-burst resync, then a 10-tick freeze inside the restarted burst
    pulse_sync();
    run(99);
    pulse_sync();
    run(120);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(200);

    // asynchronous reset mid-burst, between clock edges
    pulse_sync();
    run(150);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_chroma", int'(co), 0);
    chk("async_rst_burst", int'(ba), 0);
    chk("async_rst_valid", int'(ov), 0);
    chk("async_rst_carrier", int'(cp), 0);
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    run(250);

    // randomized pixels, enables and line syncs
    for (int i = 0; i < 2500; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      ls   = ($urandom_range(0, 299) == 0);
      ph   = 4'($urandom_range(0, 15));
      amp  = 4'($urandom_range(0, 15));
      bamp = 4'($urandom_range(0, 15));
      cen  = 1'($urandom_range(0, 1));
      tick();
    end
    ls = 1'b0;
    en = 1'b1;
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
